// File: rtl/systolic_ctrl_if.sv
// Handshake and operand/edge bus between the systolic sequencer, its operand buffers and the array edges.
// The master side drives requests and buffer read data; the slave side is the sequencer.
interface systolic_ctrl_if #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] k_len;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [N*DW-1:0]   rd_a_data;
  logic [N*DW-1:0]   rd_w_data;
  logic [N*DW-1:0]   a_edge;
  logic [N*DW-1:0]   w_edge;
  logic              capture;

  modport master (
    output start, k_len, rd_a_data, rd_w_data,
    input  busy, done, rd_en, rd_addr, a_edge, w_edge, capture
  );

  modport slave (
    input  start, k_len, rd_a_data, rd_w_data,
    output busy, done, rd_en, rd_addr, a_edge, w_edge, capture
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for the NxN systolic MAC array: streams K operand beats with diagonal edge skew,
// flushes zeros through the array for a fixed drain time, then strobes result capture.
module systolic_ctrl #(
  parameter int N            = 4,
  parameter int DW           = 8,
  parameter int ADDR_W       = 8,
  parameter int DRAIN_CYCLES = 10
) (
  input logic           clk,
  input logic           rst,
  systolic_ctrl_if.slave bus
);

  localparam int FLUSH_LEN = N + DRAIN_CYCLES + 1;
  localparam int FW        = $clog2(FLUSH_LEN + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    CAPT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] beatCnt_q, beatCnt_d;
  logic [ADDR_W-1:0] kLen_q, kLen_d;
  logic [FW-1:0]     flushCnt_q, flushCnt_d;
  logic              rdValid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beatCnt_q  <= '0;
      kLen_q     <= '0;
      flushCnt_q <= '0;
      rdValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beatCnt_q  <= beatCnt_d;
      kLen_q     <= kLen_d;
      flushCnt_q <= flushCnt_d;
      rdValid_q  <= (state_q == LOAD);
    end
  end

  // The flush length is fixed regardless of K, so capture lands K + N + DRAIN_CYCLES + 2 after start.
  always_comb begin
    state_d    = state_q;
    beatCnt_d  = beatCnt_q;
    kLen_d     = kLen_q;
    flushCnt_d = flushCnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          kLen_d     = bus.k_len;
          beatCnt_d  = '0;
          flushCnt_d = '0;
          state_d    = (bus.k_len == '0) ? FLUSH : LOAD;
        end
      end
      LOAD: begin
        if (beatCnt_q == kLen_q - 1'b1) begin
          flushCnt_d = '0;
          state_d    = FLUSH;
        end else begin
          beatCnt_d = beatCnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (flushCnt_q == FLUSH_LAST) begin
          state_d = CAPT;
        end else begin
          flushCnt_d = flushCnt_q + 1'b1;
        end
      end
      CAPT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == CAPT);
  assign bus.capture = (state_q == CAPT);
  assign bus.rd_en   = (state_q == LOAD);
  assign bus.rd_addr = (state_q == LOAD) ? beatCnt_q : '0;

  // Lane i sits behind i+1 register stages; zeros enter whenever no beat is returning.
  for (genvar lane = 0; lane < N; lane++) begin : g_lane
    logic [DW-1:0] aPipe_q [lane+1];
    logic [DW-1:0] wPipe_q [lane+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= lane; s++) begin
          aPipe_q[s] <= '0;
          wPipe_q[s] <= '0;
        end
      end else begin
        aPipe_q[0] <= rdValid_q ? bus.rd_a_data[lane*DW +: DW] : '0;
        wPipe_q[0] <= rdValid_q ? bus.rd_w_data[lane*DW +: DW] : '0;
        for (int s = 1; s <= lane; s++) begin
          aPipe_q[s] <= aPipe_q[s-1];
          wPipe_q[s] <= wPipe_q[s-1];
        end
      end
    end

    assign bus.a_edge[lane*DW +: DW] = aPipe_q[lane];
    assign bus.w_edge[lane*DW +: DW] = wPipe_q[lane];
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: reset, K=4 / K=0 / K=255 runs, ignored starts and mid-run reset.
// An operand-buffer responder returns beat data one cycle after rd_en and drives junk otherwise.
module tb_systolic_ctrl;

  localparam int N            = 4;
  localparam int DW           = 8;
  localparam int ADDR_W       = 8;
  localparam int DRAIN_CYCLES = 10;
  localparam int LAT          = N + DRAIN_CYCLES + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic              prevEn;
  logic [ADDR_W-1:0] prevAddr;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .DW(DW), .ADDR_W(ADDR_W)) bus ();

  systolic_ctrl #(
    .N(N), .DW(DW), .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Beat b, lane i carries 4*b + i + base (A uses base 1, W uses base 9).
  function automatic logic [N*DW-1:0] beatData(int b, int base);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(4*b + i + base);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] expEdge(int c, int t0, int k, int base);
    logic [N*DW-1:0] v;
    v = '0;
    if (t0 >= 0) begin
      for (int i = 0; i < N; i++) begin
        int b;
        b = c - t0 - 3 - i;
        if (b >= 0 && b < k) v[i*DW +: DW] = DW'(4*b + i + base);
      end
    end
    return v;
  endfunction

  function automatic bit expBusy(int c, int t0, int k);
    return (t0 >= 0) && (c > t0) && (c <= t0 + k + LAT);
  endfunction

  function automatic bit expCapt(int c, int t0, int k);
    return (t0 >= 0) && (c == t0 + k + LAT);
  endfunction

  function automatic bit expRd(int c, int t0, int k);
    return (t0 >= 0) && (c > t0) && (c <= t0 + k);
  endfunction

  // Advance to the middle of the next cycle and play the operand buffer's role.
  task automatic tick();
    @(negedge clk);
    cyc++;
    bus.rd_a_data = prevEn ? beatData(int'(prevAddr), 1) : {N{8'hEE}};
    bus.rd_w_data = prevEn ? beatData(int'(prevAddr), 9) : {N{8'hDD}};
    prevEn   = bus.rd_en;
    prevAddr = bus.rd_addr;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.capture !== 1'b0) begin errors++; $display("[TB] FAIL reset_capture got=%b exp=0", bus.capture); end
    checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got=%b exp=0", bus.rd_en); end
    checks++; if (bus.rd_addr !== '0) begin errors++; $display("[TB] FAIL reset_rd_addr got=%h exp=0", bus.rd_addr); end
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy cyc=%0d got=%b exp=0", cyc, bus.busy); end
      checks++; if (bus.done !== 1'b0 || bus.capture !== 1'b0) begin errors++; $display("[TB] FAIL idle_done_capture cyc=%0d got=%b%b exp=00", cyc, bus.done, bus.capture); end
      checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_rd_en cyc=%0d got=%b exp=0", cyc, bus.rd_en); end
      checks++; if (bus.a_edge !== '0 || bus.w_edge !== '0) begin errors++; $display("[TB] FAIL idle_edges cyc=%0d got=%h/%h exp=0/0", cyc, bus.a_edge, bus.w_edge); end
    end
  endtask

  task automatic test_basic();
    int t0;
    int k;
    t0 = 10;
    k = 4;
    cyc = 0;
    for (int n = 0; n < 34; n++) begin
      tick();
      checks++; if (bus.busy !== expBusy(cyc, t0, k)) begin errors++; $display("[TB] FAIL basic_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, expBusy(cyc, t0, k)); end
      checks++; if (bus.capture !== expCapt(cyc, t0, k)) begin errors++; $display("[TB] FAIL basic_capture cyc=%0d got=%b exp=%b", cyc, bus.capture, expCapt(cyc, t0, k)); end
      checks++; if (bus.done !== expCapt(cyc, t0, k)) begin errors++; $display("[TB] FAIL basic_done cyc=%0d got=%b exp=%b", cyc, bus.done, expCapt(cyc, t0, k)); end
      checks++; if (bus.rd_en !== expRd(cyc, t0, k)) begin errors++; $display("[TB] FAIL basic_rd_en cyc=%0d got=%b exp=%b", cyc, bus.rd_en, expRd(cyc, t0, k)); end
      if (expRd(cyc, t0, k)) begin
        checks++; if (bus.rd_addr !== ADDR_W'(cyc - t0 - 1)) begin errors++; $display("[TB] FAIL basic_rd_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rd_addr, cyc - t0 - 1); end
      end
      checks++; if (bus.a_edge !== expEdge(cyc, t0, k, 1)) begin errors++; $display("[TB] FAIL basic_a_edge cyc=%0d got=%h exp=%h", cyc, bus.a_edge, expEdge(cyc, t0, k, 1)); end
      checks++; if (bus.w_edge !== expEdge(cyc, t0, k, 9)) begin errors++; $display("[TB] FAIL basic_w_edge cyc=%0d got=%h exp=%h", cyc, bus.w_edge, expEdge(cyc, t0, k, 9)); end
      if (cyc == 13) begin
        checks++; if (bus.a_edge !== 32'h0000_0001) begin errors++; $display("[TB] FAIL basic_a_edge_13 got=%h exp=00000001", bus.a_edge); end
        checks++; if (bus.w_edge !== 32'h0000_0009) begin errors++; $display("[TB] FAIL basic_w_edge_13 got=%h exp=00000009", bus.w_edge); end
      end
      if (cyc == 16) begin
        checks++; if (bus.a_edge !== 32'h0407_0A0D) begin errors++; $display("[TB] FAIL basic_a_edge_16 got=%h exp=04070a0d", bus.a_edge); end
      end
      bus.start = (cyc == t0);
      bus.k_len = ADDR_W'(k);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_k0();
    int t0;
    t0 = 5;
    cyc = 0;
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++; if (bus.busy !== expBusy(cyc, t0, 0)) begin errors++; $display("[TB] FAIL k0_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, expBusy(cyc, t0, 0)); end
      checks++; if (bus.capture !== expCapt(cyc, t0, 0) || bus.done !== expCapt(cyc, t0, 0)) begin errors++; $display("[TB] FAIL k0_capture_done cyc=%0d got=%b%b exp=%b", cyc, bus.capture, bus.done, expCapt(cyc, t0, 0)); end
      checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("[TB] FAIL k0_rd_en cyc=%0d got=%b exp=0", cyc, bus.rd_en); end
      checks++; if (bus.a_edge !== '0 || bus.w_edge !== '0) begin errors++; $display("[TB] FAIL k0_edges cyc=%0d got=%h/%h exp=0/0", cyc, bus.a_edge, bus.w_edge); end
      bus.start = (cyc == t0);
      bus.k_len = '0;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_ignored_start();
    int t1;
    int k1;
    int t2;
    int k2;
    logic eBusy;
    logic eCapt;
    logic eRd;
    t1 = 10; k1 = 4; t2 = 31; k2 = 2;
    cyc = 0;
    for (int n = 0; n < 52; n++) begin
      tick();
      eBusy = expBusy(cyc, t1, k1) || expBusy(cyc, t2, k2);
      eCapt = expCapt(cyc, t1, k1) || expCapt(cyc, t2, k2);
      eRd   = expRd(cyc, t1, k1) || expRd(cyc, t2, k2);
      checks++; if (bus.busy !== eBusy) begin errors++; $display("[TB] FAIL ign_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, eBusy); end
      checks++; if (bus.capture !== eCapt || bus.done !== eCapt) begin errors++; $display("[TB] FAIL ign_capture_done cyc=%0d got=%b%b exp=%b", cyc, bus.capture, bus.done, eCapt); end
      checks++; if (bus.rd_en !== eRd) begin errors++; $display("[TB] FAIL ign_rd_en cyc=%0d got=%b exp=%b", cyc, bus.rd_en, eRd); end
      if (expRd(cyc, t2, k2)) begin
        checks++; if (bus.rd_addr !== ADDR_W'(cyc - t2 - 1)) begin errors++; $display("[TB] FAIL ign_rd_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rd_addr, cyc - t2 - 1); end
      end
      checks++; if (bus.a_edge !== (expEdge(cyc, t1, k1, 1) | expEdge(cyc, t2, k2, 1))) begin errors++; $display("[TB] FAIL ign_a_edge cyc=%0d got=%h exp=%h", cyc, bus.a_edge, expEdge(cyc, t1, k1, 1) | expEdge(cyc, t2, k2, 1)); end
      bus.start = (cyc == 10) || (cyc == 12) || (cyc == 30) || (cyc == 31);
      bus.k_len = (cyc == 10) ? ADDR_W'(k1) : (cyc == 31) ? ADDR_W'(k2) : ADDR_W'(7);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid(input int rc);
    int t1;
    int t2;
    int k;
    int e1;
    t1 = 10; t2 = rc + 10; k = 4;
    cyc = 0;
    for (int n = 0; n < rc + 34; n++) begin
      tick();
      e1 = (cyc <= rc) ? t1 : -1;
      checks++; if (bus.busy !== (expBusy(cyc, e1, k) || expBusy(cyc, t2, k))) begin errors++; $display("[TB] FAIL rmid_busy rc=%0d cyc=%0d got=%b", rc, cyc, bus.busy); end
      checks++; if (bus.capture !== expCapt(cyc, t2, k) || bus.done !== expCapt(cyc, t2, k)) begin errors++; $display("[TB] FAIL rmid_capture_done rc=%0d cyc=%0d got=%b%b exp=%b", rc, cyc, bus.capture, bus.done, expCapt(cyc, t2, k)); end
      checks++; if (bus.rd_en !== (expRd(cyc, e1, k) || expRd(cyc, t2, k))) begin errors++; $display("[TB] FAIL rmid_rd_en rc=%0d cyc=%0d got=%b", rc, cyc, bus.rd_en); end
      checks++; if (bus.a_edge !== (expEdge(cyc, e1, k, 1) | expEdge(cyc, t2, k, 1))) begin errors++; $display("[TB] FAIL rmid_a_edge rc=%0d cyc=%0d got=%h exp=%h", rc, cyc, bus.a_edge, expEdge(cyc, e1, k, 1) | expEdge(cyc, t2, k, 1)); end
      checks++; if (bus.w_edge !== (expEdge(cyc, e1, k, 9) | expEdge(cyc, t2, k, 9))) begin errors++; $display("[TB] FAIL rmid_w_edge rc=%0d cyc=%0d got=%h exp=%h", rc, cyc, bus.w_edge, expEdge(cyc, e1, k, 9) | expEdge(cyc, t2, k, 9)); end
      if (cyc == rc) begin
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.capture !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL rmid_async_ctrl rc=%0d got=%b%b%b%b exp=0000", rc, bus.busy, bus.rd_en, bus.capture, bus.done); end
        checks++; if (bus.a_edge !== '0 || bus.w_edge !== '0) begin errors++; $display("[TB] FAIL rmid_async_edges rc=%0d got=%h/%h exp=0/0", rc, bus.a_edge, bus.w_edge); end
      end
      if (cyc == rc + 2) rst = 1'b0;
      bus.start = (cyc == t1) || (cyc == t2);
      bus.k_len = ADDR_W'(k);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_k255();
    int t0;
    int k;
    t0 = 2;
    k = 255;
    cyc = 0;
    for (int n = 0; n < 280; n++) begin
      tick();
      checks++; if (bus.busy !== expBusy(cyc, t0, k)) begin errors++; $display("[TB] FAIL k255_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, expBusy(cyc, t0, k)); end
      checks++; if (bus.capture !== expCapt(cyc, t0, k) || bus.done !== expCapt(cyc, t0, k)) begin errors++; $display("[TB] FAIL k255_capture_done cyc=%0d got=%b%b exp=%b", cyc, bus.capture, bus.done, expCapt(cyc, t0, k)); end
      checks++; if (bus.rd_en !== expRd(cyc, t0, k)) begin errors++; $display("[TB] FAIL k255_rd_en cyc=%0d got=%b exp=%b", cyc, bus.rd_en, expRd(cyc, t0, k)); end
      if (expRd(cyc, t0, k)) begin
        checks++; if (bus.rd_addr !== ADDR_W'(cyc - t0 - 1)) begin errors++; $display("[TB] FAIL k255_rd_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rd_addr, cyc - t0 - 1); end
      end
      checks++; if (bus.a_edge !== expEdge(cyc, t0, k, 1)) begin errors++; $display("[TB] FAIL k255_a_edge cyc=%0d got=%h exp=%h", cyc, bus.a_edge, expEdge(cyc, t0, k, 1)); end
      if (cyc == t0 + 271) begin
        checks++; if (bus.capture !== 1'b1) begin errors++; $display("[TB] FAIL k255_capture_271 got=%b exp=1", bus.capture); end
      end
      bus.start = (cyc == t0);
      bus.k_len = ADDR_W'(k);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    prevEn        = 1'b0;
    prevAddr      = '0;
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.rd_a_data = '0;
    bus.rd_w_data = '0;
    test_reset();
    test_basic();
    test_k0();
    test_ignored_start();
    test_reset_mid(20);
    test_reset_mid(15);
    test_k255();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
